// File: rtl/jtag_tap_sequencer_pkg.sv
// rtl/jtag_tap_sequencer_pkg.sv - TAP state encoding shared by the sequencer, its FSM and benches
package jtag_tap_sequencer_pkg;

  localparam int TAP_STATE_W = 4;

  // 1149.1 reference encoding; TLR is all-ones so a stuck-high state bus reads as reset.
  typedef enum logic [TAP_STATE_W-1:0] {
    TAP_TLR    = 4'hF,
    TAP_RTI    = 4'hC,
    TAP_SEL_DR = 4'h7,
    TAP_CAP_DR = 4'h6,
    TAP_SH_DR  = 4'h2,
    TAP_EX1_DR = 4'h1,
    TAP_PA_DR  = 4'h3,
    TAP_EX2_DR = 4'h0,
    TAP_UP_DR  = 4'h5,
    TAP_SEL_IR = 4'h4,
    TAP_CAP_IR = 4'hE,
    TAP_SH_IR  = 4'hA,
    TAP_EX1_IR = 4'h9,
    TAP_PA_IR  = 4'hB,
    TAP_EX2_IR = 4'h8,
    TAP_UP_IR  = 4'hD
  } tap_state_e;

endpackage

// File: rtl/jtag_tap_fsm.sv
// rtl/jtag_tap_fsm.sv - 16-state TAP controller state register and next-state logic
module jtag_tap_fsm
  import jtag_tap_sequencer_pkg::*;
(
  input  logic                   tck,
  input  logic                   aclr,
  input  logic                   tms,
  output logic [TAP_STATE_W-1:0] state
);

  tap_state_e r_state;
  tap_state_e w_next;

  always_ff @(posedge tck) begin
    if (aclr) begin
      r_state <= TAP_TLR;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = TAP_TLR;
    case (r_state)
      TAP_TLR:    w_next = tms ? TAP_TLR    : TAP_RTI;
      TAP_RTI:    w_next = tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_DR: w_next = tms ? TAP_SEL_IR : TAP_CAP_DR;
      TAP_CAP_DR: w_next = tms ? TAP_EX1_DR : TAP_SH_DR;
      TAP_SH_DR:  w_next = tms ? TAP_EX1_DR : TAP_SH_DR;
      TAP_EX1_DR: w_next = tms ? TAP_UP_DR  : TAP_PA_DR;
      TAP_PA_DR:  w_next = tms ? TAP_EX2_DR : TAP_PA_DR;
      TAP_EX2_DR: w_next = tms ? TAP_UP_DR  : TAP_SH_DR;
      TAP_UP_DR:  w_next = tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_IR: w_next = tms ? TAP_TLR    : TAP_CAP_IR;
      TAP_CAP_IR: w_next = tms ? TAP_EX1_IR : TAP_SH_IR;
      TAP_SH_IR:  w_next = tms ? TAP_EX1_IR : TAP_SH_IR;
      TAP_EX1_IR: w_next = tms ? TAP_UP_IR  : TAP_PA_IR;
      TAP_PA_IR:  w_next = tms ? TAP_EX2_IR : TAP_PA_IR;
      TAP_EX2_IR: w_next = tms ? TAP_UP_IR  : TAP_SH_IR;
      TAP_UP_IR:  w_next = tms ? TAP_SEL_DR : TAP_RTI;
      default:    w_next = TAP_TLR;
    endcase
  end

  assign state = r_state;

endmodule

// File: rtl/jtag_tap_sequencer.sv
// rtl/jtag_tap_sequencer.sv - TAP controller with instruction register driving a JTAG DR block
module jtag_tap_sequencer
  import jtag_tap_sequencer_pkg::*;
#(
  parameter int unsigned           IR_WIDTH   = 1,
  parameter logic [IR_WIDTH-1:0]   IR_RESET   = '0,
  parameter logic [IR_WIDTH-1:0]   IR_CAPTURE = IR_WIDTH'(1)
) (
  input  logic                   tck,
  input  logic                   aclr,
  input  logic                   tms,
  input  logic                   tdi,
  input  logic                   dr_tdo,
  output logic                   tdo,
  output logic [IR_WIDTH-1:0]    ir_in,
  output logic                   v_cdr,
  output logic                   v_sdr,
  output logic                   udr,
  output logic                   uir,
  output logic [TAP_STATE_W-1:0] state
);

  logic [TAP_STATE_W-1:0] w_state;
  logic [IR_WIDTH-1:0]    r_ir_shift;
  logic [IR_WIDTH-1:0]    r_ir_in;
  logic [IR_WIDTH-1:0]    w_ir_shift_next;

  jtag_tap_fsm u_fsm (
    .tck   (tck),
    .aclr  (aclr),
    .tms   (tms),
    .state (w_state)
  );

  // tdi enters at the MSB so the LSB is the first bit presented on tdo.
  always_comb begin
    w_ir_shift_next = r_ir_shift >> 1;
    w_ir_shift_next[IR_WIDTH-1] = tdi;
  end

  always_ff @(posedge tck) begin
    if (aclr) begin
      r_ir_shift <= '0;
      r_ir_in    <= IR_RESET;
    end else begin
      case (w_state)
        TAP_CAP_IR: r_ir_shift <= IR_CAPTURE;
        TAP_SH_IR:  r_ir_shift <= w_ir_shift_next;
        TAP_UP_IR:  r_ir_in    <= r_ir_shift;
        TAP_TLR:    r_ir_in    <= IR_RESET;
        default:    r_ir_in    <= r_ir_in;
      endcase
    end
  end

  assign v_cdr = (w_state == TAP_CAP_DR);
  assign v_sdr = (w_state == TAP_SH_DR);
  assign udr   = (w_state == TAP_UP_DR);
  assign uir   = (w_state == TAP_UP_IR);
  assign state = w_state;
  assign ir_in = r_ir_in;
  assign tdo   = (w_state == TAP_SH_IR) ? r_ir_shift[0] : dr_tdo;

endmodule

// File: tb/tb_jtag_tap_sequencer.sv
// tb/tb_jtag_tap_sequencer.sv - directed scoreboard bench for jtag_tap_sequencer
module tb_jtag_tap_sequencer;

  logic       tck = 1'b0;
  logic       aclr = 1'b1;
  logic       tms = 1'b1;
  logic       tdi = 1'b0;
  logic       dr_tdo;
  logic       tdo;
  logic [0:0] ir_in;
  logic       v_cdr;
  logic       v_sdr;
  logic       udr;
  logic       uir;
  logic [3:0] state;

  logic [7:0] r_dr = 8'h00;
  logic [7:0] r_hold = 8'h00;

  int n_cmp = 0;
  int n_fail = 0;
  int n_sdr = 0;
  int n_cdr = 0;
  int n_udr = 0;
  int n_uir = 0;
  logic [3:0] m_state = 4'hF;
  logic [3:0] exp_q[$];

  jtag_tap_sequencer dut (
    .tck    (tck),
    .aclr   (aclr),
    .tms    (tms),
    .tdi    (tdi),
    .dr_tdo (dr_tdo),
    .tdo    (tdo),
    .ir_in  (ir_in),
    .v_cdr  (v_cdr),
    .v_sdr  (v_sdr),
    .udr    (udr),
    .uir    (uir),
    .state  (state)
  );

  always #5 tck = ~tck;

  // Stand-in data-register block: 8-bit LSB-first shifter with an update latch.
  always_ff @(posedge tck) begin
    if (v_sdr) r_dr <= {tdi, r_dr[7:1]};
    if (udr) r_hold <= r_dr;
  end
  assign dr_tdo = r_dr[0];

  function automatic logic [3:0] model_next(input logic [3:0] s, input logic t);
    case (s)
      4'hF: return t ? 4'hF : 4'hC;
      4'hC: return t ? 4'h7 : 4'hC;
      4'h7: return t ? 4'h4 : 4'h6;
      4'h6: return t ? 4'h1 : 4'h2;
      4'h2: return t ? 4'h1 : 4'h2;
      4'h1: return t ? 4'h5 : 4'h3;
      4'h3: return t ? 4'h0 : 4'h3;
      4'h0: return t ? 4'h5 : 4'h2;
      4'h5: return t ? 4'h7 : 4'hC;
      4'h4: return t ? 4'hF : 4'hE;
      4'hE: return t ? 4'h9 : 4'hA;
      4'hA: return t ? 4'h9 : 4'hA;
      4'h9: return t ? 4'hD : 4'hB;
      4'hB: return t ? 4'h8 : 4'hB;
      4'h8: return t ? 4'hD : 4'hA;
      4'hD: return t ? 4'h7 : 4'hC;
      default: return 4'hF;
    endcase
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic t_tms, input logic t_tdi, input logic t_rst);
    aclr = t_rst;
    tms  = t_tms;
    tdi  = t_tdi;
    m_state = t_rst ? 4'hF : model_next(m_state, t_tms);
    exp_q.push_back(m_state);
    @(posedge tck);
    #1;
    check("state", 8'(state), 8'(exp_q.pop_front()));
    if (v_sdr) n_sdr++;
    if (v_cdr) n_cdr++;
    if (udr) n_udr++;
    if (uir) n_uir++;
    aclr = 1'b0;
  endtask

  task automatic clear_counts();
    n_sdr = 0;
    n_cdr = 0;
    n_udr = 0;
    n_uir = 0;
  endtask

  initial begin
    logic [7:0] pat;

    // Reset
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    check("rst_state", 8'(state), 8'h0F);
    check("rst_ir_in", 8'(ir_in), 8'h00);
    check("rst_v_sdr", 8'(v_sdr), 8'h00);
    check("rst_udr", 8'(udr), 8'h00);
    check("rst_uir", 8'(uir), 8'h00);

    // Five tms=1 from SH_DR reach TLR; TLR holds under tms=1
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check("in_sh_dr", 8'(state), 8'h02);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b0);
    check("five_tms_tlr", 8'(state), 8'h0F);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    check("tlr_hold", 8'(state), 8'h0F);

    // IR scan loading instruction 1
    clear_counts();
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check("ir_capture_tdo", 8'(tdo), 8'h01);
    tick(1'b1, 1'b1, 1'b0);
    check("ir_in_before_update", 8'(ir_in), 8'h00);
    tick(1'b1, 1'b0, 1'b0);
    check("uir_in_up_ir", 8'(uir), 8'h01);
    tick(1'b0, 1'b0, 1'b0);
    check("uir_pulses", 8'(n_uir), 8'd1);
    check("ir_in_loaded", 8'(ir_in), 8'h01);

    // Straight DR scan of 0xA5
    clear_counts();
    pat = 8'hA5;
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check("v_cdr_in_cap", 8'(v_cdr), 8'h01);
    tick(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) tick((i == 7), pat[i], 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check("dr_cdr_count", 8'(n_cdr), 8'd1);
    check("dr_sdr_count", 8'(n_sdr), 8'd8);
    check("dr_udr_count", 8'(n_udr), 8'd1);
    check("dr_value_a5", r_hold, 8'hA5);
    check("ir_in_stable_dr", 8'(ir_in), 8'h01);

    // DR scan of 0x3C with a 3-cycle PA_DR detour after four bits
    clear_counts();
    pat = 8'h3C;
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick((i == 3), pat[i], 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check("pa_dr_v_sdr", 8'(v_sdr), 8'h00);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check("pa_dr_sdr_count", 8'(n_sdr), 8'd4);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    for (int i = 4; i < 8; i++) tick((i == 7), pat[i], 1'b0);
    check("no_udr_before_up", 8'(n_udr), 8'd0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check("pause_sdr_count", 8'(n_sdr), 8'd8);
    check("pause_udr_count", 8'(n_udr), 8'd1);
    check("dr_value_3c", r_hold, 8'h3C);

    // Reset during the third SH_IR cycle
    clear_counts();
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    check("sh_ir_third_tdo", 8'(tdo), 8'h01);
    tick(1'b0, 1'b1, 1'b1);
    check("mid_shift_rst_state", 8'(state), 8'h0F);
    check("mid_shift_rst_ir_in", 8'(ir_in), 8'h00);
    check("tdo_follows_dr", 8'(tdo), 8'(r_dr[0]));
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    check("no_uir_after_rst", 8'(n_uir), 8'd0);
    check("ir_in_after_rst", 8'(ir_in), 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
